// File: rtl/register_file.sv
// 8 x 16-bit register file with two asynchronous read ports and one synchronous write port.
// Register 0 is hardwired to zero; the full contents are exported as a flat observation bus.
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          RA,
    input  logic [ADDR_WIDTH-1:0]          RB,
    input  logic [ADDR_WIDTH-1:0]          RW,
    input  logic [DATA_WIDTH-1:0]          WD,
    input  logic                           RegWrite,
    input  logic                           rf_enable,
    output logic [DATA_WIDTH-1:0]          BusA,
    output logic [DATA_WIDTH-1:0]          BusB,
    output logic [NUM_REGS*DATA_WIDTH-1:0] registers
);

    // No storage exists for register 0; it is produced as a constant wherever it is observed.
    logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (rf_enable && RegWrite && (RW != '0)) begin
            mem[RW] <= WD;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] data;
        data = '0;
        if (addr != '0) begin
            data = mem[addr];
        end
        return data;
    endfunction

    always_comb begin
        BusA = '0;
        BusB = '0;
        if (rf_enable) begin
            BusA = read_port(RA);
            BusB = read_port(RB);
        end
    end

    assign registers[DATA_WIDTH-1:0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_image
        assign registers[DATA_WIDTH*g +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes hand-computed expectations,
// a monitor process pops them and compares against the read buses and register image.
module tb_register_file;

    logic         clk;
    logic         rst;
    logic [2:0]   RA;
    logic [2:0]   RB;
    logic [2:0]   RW;
    logic [15:0]  WD;
    logic         RegWrite;
    logic         rf_enable;
    logic [15:0]  BusA;
    logic [15:0]  BusB;
    logic [127:0] registers;

    logic clk_run;

    typedef struct {
        string        name;
        logic [15:0]  bus_a;
        logic [15:0]  bus_b;
        logic [127:0] image;
    } expect_t;

    expect_t     sb[$];
    event        sample_ev;
    logic [15:0] exp_regs [8];
    int          checks;
    int          failures;

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .RA        (RA),
        .RB        (RB),
        .RW        (RW),
        .WD        (WD),
        .RegWrite  (RegWrite),
        .rf_enable (rf_enable),
        .BusA      (BusA),
        .BusB      (BusB),
        .registers (registers)
    );

    // Clock can be parked low so reset can be shown to act without any edge.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    function automatic logic [127:0] pack_image();
        logic [127:0] img;
        img = '0;
        for (int i = 0; i < 8; i++) img[16*i +: 16] = exp_regs[i];
        return img;
    endfunction

    task automatic clear_expected();
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0000;
    endtask

    // Write through the port; 'effect' says whether the bench expects the write to land.
    task automatic do_write(input logic [2:0] addr, input logic [15:0] data,
                            input logic en, input logic effect);
        @(negedge clk);
        RW        = addr;
        WD        = data;
        RegWrite  = 1'b1;
        rf_enable = en;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        if (effect) exp_regs[addr] = data;
    endtask

    task automatic check_output(input string name, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [15:0] ea, input logic [15:0] eb);
        expect_t e;
        RA = ra;
        RB = rb;
        #1;
        e.name  = name;
        e.bus_a = ea;
        e.bus_b = eb;
        e.image = pack_image();
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        expect_t e;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (BusA !== e.bus_a) begin
                    failures++;
                    $display("[TB] FAIL %s BusA actual=%h required=%h", e.name, BusA, e.bus_a);
                end
                checks++;
                if (BusB !== e.bus_b) begin
                    failures++;
                    $display("[TB] FAIL %s BusB actual=%h required=%h", e.name, BusB, e.bus_b);
                end
                checks++;
                if (registers !== e.image) begin
                    failures++;
                    $display("[TB] FAIL %s registers actual=%h required=%h", e.name, registers, e.image);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        clk_run   = 1'b1;
        rst       = 1'b1;
        RA        = 3'd0;
        RB        = 3'd0;
        RW        = 3'd0;
        WD        = 16'h0000;
        RegWrite  = 1'b0;
        rf_enable = 1'b1;
        clear_expected();

        #12;
        check_output("reset_state", 3'd1, 3'd2, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset with the clock parked.
        do_write(3'd5, 16'h1111, 1'b1, 1'b1);
        check_output("write_reg5", 3'd5, 3'd5, 16'h1111, 16'h1111);
        @(negedge clk);
        clk_run = 1'b0;
        rst     = 1'b1;
        clear_expected();
        check_output("async_reset", 3'd5, 3'd5, 16'h0000, 16'h0000);
        #8;
        rst = 1'b0;
        #1;
        check_output("after_async_reset", 3'd5, 3'd0, 16'h0000, 16'h0000);
        clk_run = 1'b1;

        do_write(3'd1, 16'h1234, 1'b1, 1'b1);
        do_write(3'd2, 16'h5678, 1'b1, 1'b1);
        check_output("basic_rw", 3'd1, 3'd2, 16'h1234, 16'h5678);

        // Same-cycle read of the register being written shows the old value first.
        @(negedge clk);
        RW       = 3'd3;
        WD       = 16'hABCD;
        RegWrite = 1'b1;
        check_output("no_bypass_before", 3'd3, 3'd1, 16'h0000, 16'h1234);
        @(posedge clk);
        #1;
        RegWrite    = 1'b0;
        exp_regs[3] = 16'hABCD;
        check_output("no_bypass_after", 3'd3, 3'd1, 16'hABCD, 16'h1234);

        // Reset mid-cycle, held across an edge carrying a write request.
        @(negedge clk);
        #2;
        rst      = 1'b1;
        RW       = 3'd6;
        WD       = 16'h7777;
        RegWrite = 1'b1;
        clear_expected();
        check_output("reset_after_writes", 3'd1, 3'd2, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        check_output("reset_overrides_write", 3'd6, 3'd6, 16'h0000, 16'h0000);
        RegWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Enable gating of reads and writes.
        do_write(3'd1, 16'h1234, 1'b1, 1'b1);
        rf_enable = 1'b0;
        check_output("disabled_read", 3'd1, 3'd1, 16'h0000, 16'h0000);
        do_write(3'd4, 16'h1234, 1'b0, 1'b0);
        check_output("disabled_write", 3'd4, 3'd1, 16'h0000, 16'h0000);
        rf_enable = 1'b1;
        check_output("enabled_no_write", 3'd4, 3'd1, 16'h0000, 16'h1234);

        do_write(3'd0, 16'hFFFF, 1'b1, 1'b0);
        check_output("reg0_hardwired", 3'd0, 3'd0, 16'h0000, 16'h0000);

        do_write(3'd2, 16'hBEEF, 1'b1, 1'b1);
        do_write(3'd3, 16'h00FF, 1'b1, 1'b1);
        do_write(3'd4, 16'hA5A5, 1'b1, 1'b1);
        do_write(3'd5, 16'h5A5A, 1'b1, 1'b1);
        do_write(3'd6, 16'h8001, 1'b1, 1'b1);
        do_write(3'd7, 16'hFFFF, 1'b1, 1'b1);
        check_output("read_7_6", 3'd7, 3'd6, 16'hFFFF, 16'h8001);
        check_output("read_same", 3'd3, 3'd3, 16'h00FF, 16'h00FF);
        check_output("read_5_4", 3'd5, 3'd4, 16'h5A5A, 16'hA5A5);
        check_output("read_2_0", 3'd2, 3'd0, 16'hBEEF, 16'h0000);
        do_write(3'd7, 16'h7E7E, 1'b1, 1'b1);
        check_output("overwrite_7", 3'd7, 3'd1, 16'h7E7E, 16'h1234);

        #20;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
